bit_serializer: RTL and testbench

BIT_SERIALIZER -- requirements
Module: bit_serializer

---
 rtl/serializer_pkg.sv | 13 +
 rtl/bit_serializer.sv | 109 ++++++++++
 tb/tb_bit_serializer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/serializer_pkg.sv
// Shared types for the bit serializer: FSM state encoding and GAP timer sizing.
package serializer_pkg;

  localparam int GAP_MAX = 15;
  localparam int GAP_W   = $clog2(GAP_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_GAP
  } state_e;

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter, MSB first, with GAP idle cycles after each frame.
// SERIALIZER_PARITY_EN appends an even-parity bit to every frame.
module bit_serializer
  import serializer_pkg::*;
#(
  parameter int N   = 8,
  parameter int GAP = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [N-1:0] in_data,
  output logic         in_ready,
  output logic         ser_data,
  output logic         ser_en,
  output logic         frame_done,
  output logic         busy
);

`ifdef SERIALIZER_PARITY_EN
  localparam int FRAME_LEN = N + 1;
`else
  localparam int FRAME_LEN = N;
`endif

  localparam int                 CNT_W    = $clog2(N + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic [GAP_W-1:0]   GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [N-1:0]       hold_q, hold_d;
  logic               done_q, done_d;
  logic [N-1:0]       hold_sh;
  logic               data_bit;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
      hold_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
    end
  end

  // Current bit: the hold register stays intact and is indexed by the counter.
  always_comb begin
    hold_sh  = hold_q << cnt_q;
    data_bit = hold_sh[N-1];
`ifdef SERIALIZER_PARITY_EN
    if (cnt_q == CNT_W'(N)) data_bit = ^hold_q;
`endif
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gap_d    = gap_q;
    hold_d   = hold_q;
    done_d   = 1'b0;
    in_ready = 1'b0;
    ser_en   = 1'b0;
    ser_data = 1'b0;
    busy     = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          hold_d  = in_data;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        ser_en   = 1'b1;
        ser_data = data_bit;
        if (cnt_q == CNT_LAST) begin
          done_d = 1'b1;
          cnt_d  = '0;
          gap_d  = '0;
          if (GAP > 0) state_d = ST_GAP;
          else         state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign frame_done = done_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: GAP=1 and GAP=0 instances share stimulus; a cycle-indexed
// schedule model predicts every output, plus literal pins on the directed scenarios.
module tb_bit_serializer;

  localparam int N    = 8;
  localparam int MAXC = 1024;
`ifdef SERIALIZER_PARITY_EN
  localparam int FL          = N + 1;
  localparam int P_STROBES   = 9;
  localparam int P_DONE_OFS  = 10;
  localparam int P_PERIOD_G1 = 11;
  localparam int P_PERIOD_G0 = 10;
  localparam int P_RDY_LOW   = 10;
`else
  localparam int FL          = N;
  localparam int P_STROBES   = 8;
  localparam int P_DONE_OFS  = 9;
  localparam int P_PERIOD_G1 = 10;
  localparam int P_PERIOD_G0 = 9;
  localparam int P_RDY_LOW   = 9;
`endif

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic [N-1:0] in_data = '0;
  logic         rdy [2];
  logic         sd  [2];
  logic         en  [2];
  logic         done[2];
  logic         bsy [2];

  always #5 clock = ~clock;

  bit_serializer #(.N(N), .GAP(1)) u_gap1 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy[0]), .ser_data(sd[0]), .ser_en(en[0]), .frame_done(done[0]), .busy(bsy[0])
  );

  bit_serializer #(.N(N), .GAP(0)) u_gap0 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy[1]), .ser_data(sd[1]), .ser_en(en[1]), .frame_done(done[1]), .busy(bsy[1])
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int gapv [2] = '{1, 0};

  // Model: per-cycle expectations, filled in when a handshake is predicted.
  bit           m_en  [2][MAXC];
  bit           m_bit [2][MAXC];
  bit           m_done[2][MAXC];
  bit           m_nrdy[2][MAXC];
  logic [N-1:0] m_word[2];

  // Observations of the downstream side.
  logic [N-1:0] sr[2], last_rx[2];
  logic         last_par[2];
  int bitcnt[2], last_cnt[2], done_cyc[2], done_seen[2];
  int hs_last[2], hs_prev[2], rlow[2], last_rlow[2], elow[2], last_elow[2];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic schedule(input int i, input int c, input logic [N-1:0] w);
    m_word[i] = w;
    for (int j = 0; j < FL; j++) begin
      m_en[i][c+1+j]  = 1'b1;
      m_bit[i][c+1+j] = (j < N) ? w[N-1-j] : ^w;
    end
    m_done[i][c+FL+1] = 1'b1;
    for (int j = 1; j <= FL + gapv[i]; j++) m_nrdy[i][c+j] = 1'b1;
  endtask

  always @(negedge clock) begin
    logic e_rdy, e_en, e_bit, e_done;
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        for (int c = cyc; c < MAXC; c++) begin
          m_en[i][c] = 0; m_bit[i][c] = 0; m_done[i][c] = 0; m_nrdy[i][c] = 0;
        end
        e_rdy = 1'b1; e_en = 1'b0; e_bit = 1'b0; e_done = 1'b0;
        bitcnt[i] = 0; sr[i] = '0;
      end else begin
        e_rdy  = !m_nrdy[i][cyc];
        e_en   = m_en[i][cyc];
        e_bit  = m_bit[i][cyc];
        e_done = m_done[i][cyc];
      end
      chk($sformatf("u%0d in_ready", i),   32'(rdy[i]),  32'(e_rdy));
      chk($sformatf("u%0d ser_en", i),     32'(en[i]),   32'(e_en));
      chk($sformatf("u%0d ser_data", i),   32'(sd[i]),   32'(e_bit));
      chk($sformatf("u%0d frame_done", i), 32'(done[i]), 32'(e_done));
      chk($sformatf("u%0d busy", i),       32'(bsy[i]),  32'(!e_rdy));

      if (!reset && in_valid && rdy[i]) begin
        hs_prev[i] = hs_last[i];
        hs_last[i] = cyc;
      end
      if (!rdy[i]) rlow[i]++;
      else if (rlow[i] > 0) begin
        last_rlow[i] = rlow[i];
        rlow[i] = 0;
      end
      if (en[i]) begin
        if (elow[i] > 0) last_elow[i] = elow[i];
        elow[i] = 0;
        if (bitcnt[i] < N) sr[i] = {sr[i][N-2:0], sd[i]};
        else               last_par[i] = sd[i];
        bitcnt[i]++;
      end else begin
        elow[i]++;
      end
      if (done[i]) begin
        last_rx[i]  = sr[i];
        last_cnt[i] = bitcnt[i];
        done_cyc[i] = cyc;
        done_seen[i]++;
        chk($sformatf("u%0d rx word", i), 32'(sr[i]), 32'(m_word[i]));
        bitcnt[i] = 0;
      end

      if (!reset && in_valid && e_rdy) schedule(i, cyc, in_data);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send_one(input logic [N-1:0] w, input int idle);
    in_valid = 1'b1;
    in_data  = w;
    step();
    in_valid = 1'b0;
    in_data  = '0;
    repeat (idle) step();
  endtask

  initial begin
    int base0, base1;
    repeat (3) step();
    reset = 1'b0;
    step();

    // Single frame A5
    send_one(8'hA5, 14);
    chk("A5 word gap1", 32'(last_rx[0]), 32'h A5);
    chk("A5 word gap0", 32'(last_rx[1]), 32'h A5);
    chk("A5 strobes", 32'(last_cnt[0]), 32'(P_STROBES));
    chk("A5 done offset", 32'(done_cyc[0] - hs_last[0]), 32'(P_DONE_OFS));

    // Continuous valid: 01 then FF
    in_valid = 1'b1;
    in_data  = 8'h01;
    step();
    in_data  = 8'hFF;
    repeat (29) step();
    in_valid = 1'b0;
    repeat (15) step();
    chk("gap1 period", 32'(hs_last[0] - hs_prev[0]), 32'(P_PERIOD_G1));
    chk("gap1 ready low", 32'(last_rlow[0]), 32'(P_RDY_LOW));
    chk("gap1 last word", 32'(last_rx[0]), 32'h FF);
    chk("gap0 period", 32'(hs_last[1] - hs_prev[1]), 32'(P_PERIOD_G0));
    chk("gap0 strobe gap", 32'(last_elow[1]), 32'd1);

    // Reset on the 4th bit of C3, then 3C
    in_valid = 1'b1;
    in_data  = 8'hC3;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    base0 = done_seen[0];
    base1 = done_seen[1];
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (12) step();
    chk("abort no done gap1", 32'(done_seen[0] - base0), 32'd0);
    chk("abort no done gap0", 32'(done_seen[1] - base1), 32'd0);
    send_one(8'h3C, 14);
    chk("3C word gap1", 32'(last_rx[0]), 32'h3C);
    chk("3C word gap0", 32'(last_rx[1]), 32'h3C);

    // in_data churns during SHIFT with in_valid held high
    in_valid = 1'b1;
    in_data  = 8'h5A;
    step();
    for (int k = 0; k < FL; k++) begin
      in_data = 8'($urandom);
      step();
    end
    in_valid = 1'b0;
    repeat (12) step();
    chk("5A word gap1", 32'(last_rx[0]), 32'h5A);
    chk("5A word gap0", 32'(last_rx[1]), 32'h5A);

    // 07: three ones, parity bit 1 when enabled
    send_one(8'h07, 14);
    chk("07 word", 32'(last_rx[0]), 32'h07);
`ifdef SERIALIZER_PARITY_EN
    chk("07 parity bit", 32'(last_par[0]), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
